// File: rtl/fifo_ram_fwft.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ram_fwft
// Description : First-word-fall-through FIFO on an inferred simple dual-port
//               RAM. The RAM's registered read port is the output register,
//               so the head-of-queue word is presented on r_data_o without a
//               prior read request. The block also provides an occupancy count,
//               programmable almost-full/almost-empty flags, a synchronous
//               flush and sticky overflow/underflow error flags.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DATA_WIDTH  bits per word
//   ADDR_WIDTH  RAM address bits, DEPTH = 2**ADDR_WIDTH words
//   AF_THRESH   almost_full_o  when count >= AF_THRESH  (1 .. DEPTH)
//   AE_THRESH   almost_empty_o when count <= AE_THRESH  (0 .. DEPTH-1)
// Ports
//   clk_i            clock, all state updates on the rising edge
//   reset_ni         asynchronous active-low reset
//   clr_i            synchronous flush (error flags are kept)
//   clr_err_i        synchronous clear of the sticky error flags
//   wr_i, w_data_i   write request and write word
//   rd_i             pop request (acknowledges r_data_o)
//   r_data_o         head-of-queue word, valid while empty_o = 0
//   empty_o          no valid word on r_data_o
//   full_o           count_o == DEPTH
//   almost_empty_o   count_o <= AE_THRESH
//   almost_full_o    count_o >= AF_THRESH
//   count_o          words stored, including the word on r_data_o
//   overflow_o       sticky: write attempted while full
//   underflow_o      sticky: read attempted while empty
// ============================================================================
module fifo_ram_fwft #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int AF_THRESH  = 2**ADDR_WIDTH - 4,
  parameter int AE_THRESH  = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  clr_i,
  input  logic                  clr_err_i,
  input  logic                  wr_i,
  input  logic [DATA_WIDTH-1:0] w_data_i,
  input  logic                  rd_i,
  output logic [DATA_WIDTH-1:0] r_data_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  almost_empty_o,
  output logic                  almost_full_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int                  c_depth     = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] c_depth_cnt = (ADDR_WIDTH+1)'(c_depth);
  localparam logic [ADDR_WIDTH:0] c_af_thresh = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] c_ae_thresh = (ADDR_WIDTH+1)'(AE_THRESH);
  localparam logic [ADDR_WIDTH:0] c_cnt_one   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] c_ptr_one = ADDR_WIDTH'(1);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  if (DATA_WIDTH < 1) begin : g_chk_data_width
    $fatal(1, "fifo_ram_fwft: DATA_WIDTH must be at least 1");
  end

  if (ADDR_WIDTH < 1) begin : g_chk_addr_width
    $fatal(1, "fifo_ram_fwft: ADDR_WIDTH must be at least 1");
  end

  if ((AF_THRESH < 1) || (AF_THRESH > c_depth)) begin : g_chk_af_thresh
    $fatal(1, "fifo_ram_fwft: AF_THRESH out of range 1..DEPTH");
  end

  if ((AE_THRESH < 0) || (AE_THRESH > c_depth - 1)) begin : g_chk_ae_thresh
    $fatal(1, "fifo_ram_fwft: AE_THRESH out of range 0..DEPTH-1");
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem_q [c_depth];

  logic [ADDR_WIDTH-1:0] w_ptr_q,     w_ptr_d;
  // Address of the next stored word to move into the output register.
  logic [ADDR_WIDTH-1:0] r_ptr_q,     r_ptr_d;
  logic [ADDR_WIDTH:0]   count_q,     count_d;
  logic                  out_valid_q, out_valid_d;
  logic                  overflow_q,  overflow_d;
  logic                  underflow_q, underflow_d;
  // RAM read register; doubles as the head-of-queue output register.
  logic [DATA_WIDTH-1:0] r_data_q;

  // --------------------------------------------------------------------------
  // Request qualification
  // --------------------------------------------------------------------------
  logic                  full;
  logic                  wr_accept;
  logic                  rd_accept;
  logic                  wr_reject;
  logic                  rd_reject;
  logic [ADDR_WIDTH:0]   ram_words;
  logic                  ram_has_word;
  logic                  load_head;

  assign full      = (count_q == c_depth_cnt);

  // Flush takes priority: requests seen together with clr_i are discarded
  // and cannot raise the error flags.
  assign wr_accept = wr_i & ~full        & ~clr_i;
  assign rd_accept = rd_i &  out_valid_q & ~clr_i;
  assign wr_reject = wr_i &  full        & ~clr_i;
  assign rd_reject = rd_i & ~out_valid_q & ~clr_i;

  // Words that sit in the RAM but not yet in the output register. When the
  // head is valid it has already been taken out of the RAM, so it is not
  // counted here.
  assign ram_words    = count_q - {{ADDR_WIDTH{1'b0}}, out_valid_q};
  assign ram_has_word = (ram_words != '0);

  // Refill the output register when it is empty or being popped this cycle.
  // Only words already written before this edge are visible, which gives the
  // one-cycle fall-through latency on an empty FIFO (no write bypass).
  assign load_head = ~clr_i & ram_has_word & (~out_valid_q | rd_accept);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_ptr_d     = w_ptr_q;
    r_ptr_d     = r_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;

    if (clr_i) begin
      w_ptr_d     = '0;
      r_ptr_d     = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      if (wr_accept) begin
        w_ptr_d = w_ptr_q + c_ptr_one;
      end

      if (load_head) begin
        r_ptr_d     = r_ptr_q + c_ptr_one;
        out_valid_d = 1'b1;
      end else if (rd_accept) begin
        out_valid_d = 1'b0;
      end

      case ({wr_accept, rd_accept})
        2'b10:   count_d = count_q + c_cnt_one;
        2'b01:   count_d = count_q - c_cnt_one;
        default: count_d = count_q;
      endcase
    end
  end

  // Sticky error flags: a new event in the same cycle as clr_err_i wins.
  always_comb begin
    overflow_d  = (overflow_q  & ~clr_err_i) | wr_reject;
    underflow_d = (underflow_q & ~clr_err_i) | rd_reject;
  end

  // --------------------------------------------------------------------------
  // Control registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      w_ptr_q     <= '0;
      r_ptr_q     <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      w_ptr_q     <= w_ptr_d;
      r_ptr_q     <= r_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // --------------------------------------------------------------------------
  // Storage: write port (no reset, maps onto block RAM)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (wr_accept) begin
      mem_q[w_ptr_q] <= w_data_i;
    end
  end

  // Registered read port with enable. Contents stay put while the head is
  // held, so r_data_o is stable until it is popped.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_data_q <= '0;
    end else if (load_head) begin
      r_data_q <= mem_q[r_ptr_q];
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign r_data_o       = r_data_q;
  assign empty_o        = ~out_valid_q;
  assign full_o         = full;
  assign almost_empty_o = (count_q <= c_ae_thresh);
  assign almost_full_o  = (count_q >= c_af_thresh);
  assign count_o        = count_q;
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_ram_fwft.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_ram_fwft
// Description : Directed self-checking bench for fifo_ram_fwft (16-word
//               configuration). Expected values are hand-derived constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_ram_fwft;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk;
  logic          reset_n;
  logic          clr;
  logic          clr_err;
  logic          wr;
  logic [DW-1:0] w_data;
  logic          rd;
  logic [DW-1:0] r_data;
  logic          empty;
  logic          full;
  logic          almost_empty;
  logic          almost_full;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  int n_cmp = 0;
  int n_err = 0;

  fifo_ram_fwft #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .AF_THRESH  (12),
    .AE_THRESH  (4)
  ) dut (
    .clk_i          (clk),
    .reset_ni       (reset_n),
    .clr_i          (clr),
    .clr_err_i      (clr_err),
    .wr_i           (wr),
    .w_data_i       (w_data),
    .rd_i           (rd),
    .r_data_o       (r_data),
    .empty_o        (empty),
    .full_o         (full),
    .almost_empty_o (almost_empty),
    .almost_full_o  (almost_full),
    .count_o        (count),
    .overflow_o     (overflow),
    .underflow_o    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past one rising edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_ae"}, 32'(almost_empty), 32'd1);
    chk({tag, "_af"}, 32'(almost_full), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
    chk({tag, "_unf"}, 32'(underflow), 32'd0);
    chk({tag, "_rdata"}, 32'(r_data), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    clr     = 1'b0;
    clr_err = 1'b0;
    wr      = 1'b0;
    w_data  = '0;
    rd      = 1'b0;

    // ---------------- reset ----------------
    tick();
    tick();
    chk_reset_state("rst");
    reset_n = 1'b1;
    tick();

    // ---------------- three writes, three pops ----------------
    wr = 1'b1; w_data = 8'h11;
    tick();
    chk("w1_count", 32'(count), 32'd1);
    chk("w1_empty", 32'(empty), 32'd1);
    w_data = 8'h22;
    tick();
    chk("w2_count", 32'(count), 32'd2);
    chk("w2_empty", 32'(empty), 32'd0);
    chk("w2_rdata", 32'(r_data), 32'h11);
    w_data = 8'h33;
    tick();
    chk("w3_count", 32'(count), 32'd3);
    chk("w3_rdata", 32'(r_data), 32'h11);
    chk("w3_ae", 32'(almost_empty), 32'd1);
    wr = 1'b0; rd = 1'b1;
    tick();
    chk("p1_rdata", 32'(r_data), 32'h22);
    chk("p1_count", 32'(count), 32'd2);
    tick();
    chk("p2_rdata", 32'(r_data), 32'h33);
    chk("p2_count", 32'(count), 32'd1);
    tick();
    chk("p3_empty", 32'(empty), 32'd1);
    chk("p3_count", 32'(count), 32'd0);
    rd = 1'b0;

    // ---------------- fill to 16 ----------------
    for (int i = 0; i < 16; i++) begin
      wr = 1'b1; w_data = 8'h40 + 8'(i);
      tick();
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_af", 32'(almost_full), (i + 1 >= 12) ? 32'd1 : 32'd0);
      chk("fill_full", 32'(full), (i + 1 == 16) ? 32'd1 : 32'd0);
      chk("fill_ae", 32'(almost_empty), (i + 1 <= 4) ? 32'd1 : 32'd0);
    end
    // 17th write with a simultaneous pop: write dropped, pop accepted.
    w_data = 8'hEE; rd = 1'b1;
    chk("ovf_head", 32'(r_data), 32'h40);
    tick();
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd15);
    chk("ovf_full", 32'(full), 32'd0);
    chk("ovf_rdata", 32'(r_data), 32'h41);
    wr = 1'b0; rd = 1'b0; clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);
    rd = 1'b1;
    for (int i = 1; i < 16; i++) begin
      chk("drain_data", 32'(r_data), 32'(8'h40 + 8'(i)));
      tick();
    end
    rd = 1'b0;
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_unf", 32'(underflow), 32'd0);

    // ---------------- streaming at count=5 ----------------
    wr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      w_data = 8'(i);
      tick();
    end
    chk("st_pre_count", 32'(count), 32'd5);
    chk("st_pre_rdata", 32'(r_data), 32'd0);
    rd = 1'b1;
    for (int k = 0; k < 100; k++) begin
      w_data = 8'(k + 5);
      chk("st_data", 32'(r_data), 32'(k));
      tick();
      chk("st_count", 32'(count), 32'd5);
    end
    wr = 1'b0;
    for (int k = 100; k < 105; k++) begin
      chk("st_tail", 32'(r_data), 32'(k));
      tick();
    end
    rd = 1'b0;
    chk("st_empty", 32'(empty), 32'd1);
    chk("st_ovf", 32'(overflow), 32'd0);
    chk("st_unf", 32'(underflow), 32'd0);

    // ---------------- underflow ----------------
    rd = 1'b1;
    tick();
    chk("unf_flag", 32'(underflow), 32'd1);
    chk("unf_count", 32'(count), 32'd0);
    rd = 1'b0; clr_err = 1'b1;
    tick();
    chk("unf_clr", 32'(underflow), 32'd0);
    rd = 1'b1;
    tick();
    chk("unf_setwins", 32'(underflow), 32'd1);
    rd = 1'b0; clr_err = 1'b0;
    tick();
    chk("unf_sticky", 32'(underflow), 32'd1);
    rd = 1'b1; wr = 1'b1; w_data = 8'h77;
    tick();
    chk("unf_wr_count", 32'(count), 32'd1);
    rd = 1'b0; wr = 1'b0;
    tick();
    chk("unf_wr_rdata", 32'(r_data), 32'h77);
    chk("unf_wr_empty", 32'(empty), 32'd0);
    rd = 1'b1;
    tick();
    chk("unf_pop_empty", 32'(empty), 32'd1);
    rd = 1'b0; clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("unf_clr2", 32'(underflow), 32'd0);

    // ---------------- flush ----------------
    wr = 1'b1; w_data = 8'hA5;
    tick();
    w_data = 8'h5A;
    tick();
    chk("clr_pre_count", 32'(count), 32'd2);
    chk("clr_pre_rdata", 32'(r_data), 32'hA5);
    clr = 1'b1; w_data = 8'hFF;
    tick();
    clr = 1'b0;
    chk("clr_count", 32'(count), 32'd0);
    chk("clr_empty", 32'(empty), 32'd1);
    chk("clr_ovf", 32'(overflow), 32'd0);
    chk("clr_unf", 32'(underflow), 32'd0);
    w_data = 8'h01;
    tick();
    chk("clr_w_count", 32'(count), 32'd1);
    chk("clr_w_empty", 32'(empty), 32'd1);
    wr = 1'b0;
    tick();
    chk("clr_w_rdata", 32'(r_data), 32'h01);
    chk("clr_w_empty2", 32'(empty), 32'd0);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    chk("clr_pop_empty", 32'(empty), 32'd1);

    // ---------------- reset mid-stream ----------------
    rd = 1'b1;
    tick();
    rd = 1'b0;
    chk("mr_unf_set", 32'(underflow), 32'd1);
    wr = 1'b1;
    for (int i = 0; i < 6; i++) begin
      w_data = 8'hC0 + 8'(i);
      tick();
    end
    wr = 1'b0;
    tick();
    chk("mr_pre_count", 32'(count), 32'd6);
    chk("mr_pre_rdata", 32'(r_data), 32'hC0);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_state("mr_async");
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    wr = 1'b1; w_data = 8'hD1;
    tick();
    w_data = 8'hD2;
    tick();
    wr = 1'b0;
    tick();
    chk("mr_post_count", 32'(count), 32'd2);
    chk("mr_post_rdata", 32'(r_data), 32'hD1);
    rd = 1'b1;
    tick();
    chk("mr_post_rdata2", 32'(r_data), 32'hD2);
    tick();
    rd = 1'b0;
    chk("mr_post_empty", 32'(empty), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
